// File: rtl/key_shift_loader.sv
// Serial key loader: receives KEY_W bits LSB first plus an even-parity bit,
// then presents the key in parallel only after a good load.
module key_shift_loader #(
    parameter int KEY_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sdata_i,
    input  logic             svalid_i,
    output logic             sready_o,
    output logic [KEY_W-1:0] key_out_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PAR  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [CW-1:0] LAST_BIT = CW'(KEY_W - 1);
    localparam logic [7:0]    GAP_LAST = 8'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [KEY_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             rdy_q, rdy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             xfer;

    assign xfer = svalid_i & rdy_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        key_d   = key_q;
        if (start_i) begin
            state_d = S_LOAD;
            shreg_d = '0;
            cnt_d   = '0;
            gap_d   = '0;
            key_d   = '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        shreg_d[cnt_q] = sdata_i;
                        gap_d          = '0;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d   = '0;
                            state_d = S_PAR;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (gap_q == GAP_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                S_PAR: begin
                    if (xfer) begin
                        gap_d = '0;
                        // Even parity: data bits and parity bit XOR to zero
                        if ((^shreg_q ^ sdata_i) == 1'b0) begin
                            key_d   = shreg_q;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (gap_q == GAP_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs come straight from flops so the downstream FSM sees no glitches
    always_comb begin
        rdy_d   = (state_d == S_LOAD) || (state_d == S_PAR);
        valid_d = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            key_q   <= '0;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            key_q   <= key_d;
            rdy_q   <= rdy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign sready_o    = rdy_q;
    assign busy_o      = rdy_q;
    assign key_out_o   = key_q;
    assign key_valid_o = valid_q;
    assign err_o       = err_q;

endmodule
